// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DATA_W     = 16;
  localparam int REQ_ADDR_W = 16;
  localparam int CNT_W      = 4;

  // An address is in range when every bit above the store's index width is zero.
  function automatic logic addr_in_range(input logic [REQ_ADDR_W-1:0] addr, input int aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word store for dmem_responder: synchronous write, registered read, no reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
//   state | meaning
//   IDLE  | ready for a request; req_ready high
//   WAIT  | request latched, counting down wait states
//   RESP  | one-cycle response strobe, then back to IDLE
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  dmem_state_t           state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [REQ_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     hold_q;
  logic                  accept;
  logic                  enter_resp;
  logic                  cur_we;
  logic [REQ_ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0]     cur_wdata;
  logic                  cur_in_range;
  logic                  latched_err;
  logic                  arr_wr;
  logic                  arr_rd;
  logic [DATA_W-1:0]     arr_rdata;

  assign accept = req_valid && req_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    busy      = 1'b1;
    rsp_rdata = hold_q;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = req_valid;
      end
      WAIT: busy = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = latched_err;
        rsp_rdata = latched_err ? '0 : (we_q ? wdata_q : arr_rdata);
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= WAIT_INIT;
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == RESP) hold_q <= rsp_rdata;
    end
  end

  // With zero wait states RESP is entered on the accepting edge itself, so the
  // array must see the live request rather than the not-yet-loaded latches.
  assign cur_we       = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr     = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata    = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_in_range = addr_in_range(cur_addr, ADDR_W);
  assign latched_err  = !addr_in_range(addr_q, ADDR_W);

  assign enter_resp = !RST && (state_nxt == RESP) && (state_q != RESP);
  assign arr_wr     = enter_resp && cur_we && cur_in_range;
  assign arr_rd     = enter_resp && !cur_we && cur_in_range;

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .CLK   (CLK),
    .wr_en (arr_wr),
    .rd_en (arr_rd),
    .addr  (cur_addr[ADDR_W-1:0]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

endmodule
